video_timing_gen: RTL
=====================

# video_timing_gen

Parametrised VGA-side timing and pixel-fetch engine, successor to the fixed-mode transmit block in the HP2VGA video path. Generates HSYNC/VSYNC/visible timing for any mode set by parameters, fetches source pixels from the ping-pong line buffer with integer horizontal/vertical scaling, and optionally genlocks its frame start to the receive side's frame pulse with timeout fallback to free-run. Sits between the line buffer read port and the ADV output registers, entirely in the TX clock domain.

## Interface
- H_VISIBLE, 800, visible pixels per line
- H_FP / H_SYNC / H_BP, 40 / 128 / 88, horizontal front porch, sync, back porch (pixels)
- V_VISIBLE, 600, visible lines per frame
- V_FP / V_SYNC / V_BP, 1 / 4 / 23, vertical porch/sync widths (lines)
- HS_POL / VS_POL, 1 / 1, sync active level
- H_SCALE / V_SCALE, 2 / 2, output pixels per source pixel / output lines per source line (>=1)
- ADDR_W, 14, line buffer address width; MSB = bank select
- WAIT_MAX, 1024, lines to wait for SYNC before giving up lock
- CLK  in  1  TX pixel clock
- RST  in  1  asynchronous, active-high reset
- ENABLE  in  1  counters advance only when high; low freezes all state
- SYNC  in  1  frame-start pulse from receive side (other domain; synchronised internally)
- SYNC_EN  in  1  1 = genlock mode, 0 = free-run
- BRAM_DOUT  in  8  line buffer read data, valid 1 cycle after BRAM_ADDR
- BRAM_ADDR  out  ADDR_W  line buffer read address
- VGA_R / VGA_G / VGA_B  out  8 each  pixel data
- VGA_HS / VGA_VS  out  1  syncs, aligned to pixel data
- VGA_VISIBLE  out  1  active-video flag, aligned to pixel data
- LOCKED  out  1  current frame was started by a SYNC edge

## Operation
- Counters h in 0..H_TOTAL-1, v in 0..V_TOTAL-1; H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP, same for V. h advances each enabled cycle; v advances when h wraps.
- Visible: h<H_VISIBLE and v<V_VISIBLE. HS active for H_VISIBLE+H_FP <= h < H_VISIBLE+H_FP+H_SYNC; VS likewise on v.
- Source x = h/H_SCALE, source y = v/V_SCALE, via sub-counters (no dividers). BRAM_ADDR = {srcy[0], srcx[ADDR_W-2:0]} while visible, 0 otherwise.
- Pixel out: visible -> R=G=B=BRAM_DOUT; else all 0.
- SYNC passes a 2-flop synchroniser; rising edge detected on synchronised value; edge sets a pending flag.
- States: RUN, WAIT.
  - RUN: counters advance. At frame end (h,v both wrap): SYNC_EN=0 -> stay RUN, LOCKED<=0; SYNC_EN=1 and pending -> stay RUN, clear pending, LOCKED<=1; SYNC_EN=1 and no pending -> WAIT.
  - WAIT: h=v=0 held, syncs inactive, VISIBLE 0; wait counter counts H_TOTAL-cycle lines. SYNC edge -> RUN next cycle, LOCKED<=1. Wait count reaches WAIT_MAX -> RUN, LOCKED<=0. SYNC_EN falling -> RUN immediately.
- Edge coinciding with frame end counts as pending. Pending cleared on entering WAIT's exit and when SYNC_EN=0.
- ENABLE low: everything frozen including wait counter; synchroniser keeps sampling, edges still latched.

## Timing
- Cycle t: counters -> BRAM_ADDR (registered, visible at t+1). t+2: BRAM_DOUT valid. t+3: VGA_R/G/B registered. HS/VS/VISIBLE delayed by matching pipeline so all outputs align (3-cycle latency from counter state).
- SYNC to state change: 2 synchroniser cycles + 1 edge-detect cycle.
- Reset: h=v=0, state RUN, pending 0, BRAM_ADDR 0, RGB 0, VGA_VISIBLE 0, VGA_HS=!HS_POL, VGA_VS=!VS_POL, LOCKED 0, pipeline cleared. Reset mid-frame aborts immediately.

## Configuration
- TEST_PATTERN_EN defined: extra input PATTERN_SEL (1 bit). When high, visible pixels are 8 vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black), bar width H_VISIBLE/8, last bar absorbs remainder; BRAM_DOUT ignored; timing unchanged. Not defined: no PATTERN_SEL port, pixel path as above.

## Test plan
- Free-run, H 8/2/2/2, V 4/1/1/1, scale 1, SYNC_EN=0 -> HS active 2 cycles every 14, VS active 14 cycles every 98, VISIBLE 32 cycles/frame, LOCKED=0.
- Scale 2x2, BRAM_DOUT = address low byte -> line 0 pixels 0,0,1,1,2,2,3,3 bank 0; lines 2-3 read bank 1.
- SYNC_EN=1, SYNC pulse mid-frame -> next frame starts without WAIT, LOCKED=1 from that frame start.
- SYNC_EN=1, no SYNC, WAIT_MAX=3 -> outputs idle 3*14 cycles after frame end, then RUN with LOCKED=0.
- Assert RST mid visible line -> all outputs at reset values same cycle; restart at h=v=0 after release.
- TEST_PATTERN_EN, PATTERN_SEL=1, H_VISIBLE=16 -> 2-pixel bars white..black, syncs unchanged.

Source files
------------

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised VGA timing generator with scaled line-buffer fetch and genlock
//
// Purpose : generates H/V sync and active-video timing for a parameterised
//           mode. It fetches source pixels from the ping-pong line buffer
//           with integer H/V scaling. When genlock is enabled, each frame
//           start waits for the receive side's frame pulse, and a line-count
//           timeout falls back to free-run.
// Macro   : TEST_PATTERN_EN adds i_pattern_sel. It selects 8 vertical colour
//           bars instead of line-buffer data.
// Ports   : i_clk          TX pixel clock
//           i_rst          asynchronous active-high reset
//           i_enable       advance enable; low freezes timing and pipeline
//           i_sync         frame-start pulse from the receive clock domain
//           i_sync_en      1 = genlock, 0 = free-run
//           i_bram_dout    line buffer data, valid one cycle after o_bram_addr
//           i_pattern_sel  (TEST_PATTERN_EN only) colour-bar select
//           o_bram_addr    line buffer address; MSB selects the bank
//           o_vga_r/g/b    pixel data
//           o_vga_hs/vs    syncs, aligned with the pixel data
//           o_vga_visible  active-video flag, aligned with the pixel data
//           o_locked       current frame was started by a SYNC edge
module video_timing_gen #(
  parameter int unsigned H_VISIBLE = 800,
  parameter int unsigned H_FP      = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BP      = 88,
  parameter int unsigned V_VISIBLE = 600,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BP      = 23,
  parameter bit          HS_POL    = 1'b1,
  parameter bit          VS_POL    = 1'b1,
  parameter int unsigned H_SCALE   = 2,
  parameter int unsigned V_SCALE   = 2,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned WAIT_MAX  = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_sync,
  input  logic              i_sync_en,
  input  logic [7:0]        i_bram_dout,
`ifdef TEST_PATTERN_EN
  input  logic              i_pattern_sel,
`endif
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [7:0]        o_vga_r,
  output logic [7:0]        o_vga_g,
  output logic [7:0]        o_vga_b,
  output logic              o_vga_hs,
  output logic              o_vga_vs,
  output logic              o_vga_visible,
  output logic              o_locked
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int HSW = $clog2(H_SCALE) + 1;
  localparam int VSW = $clog2(V_SCALE) + 1;
  localparam int WCW = $clog2(WAIT_MAX) + 1;
  localparam logic [HW-1:0]  H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]  V_LAST = VW'(V_TOTAL - 1);
  localparam logic [WCW-1:0] W_LAST = WCW'(WAIT_MAX - 1);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t            r_state, w_state_nxt;
  logic [HW-1:0]     r_h, r_srcx, r_wait_h;
  logic [VW-1:0]     r_v, r_srcy;
  logic [HSW-1:0]    r_hsub;
  logic [VSW-1:0]    r_vsub;
  logic [WCW-1:0]    r_wait_cnt;
  logic              r_sync_m, r_sync_s, r_sync_d, r_pending, r_locked, r_en_d;
  logic              w_locked_nxt, w_pend_clr, w_edge, w_pend_any;
  logic              w_h_last, w_v_last, w_frame_end, w_wait_done;
  logic              w_vis, w_hs, w_vs;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_p1, r_p2, r_p3;   // {visible, hs active, vs active}
  logic [7:0]        r_r, r_g, r_b, r_dout_hold, w_pix;
`ifdef TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;
  logic [HW-1:0] r_bar_px;
  logic [2:0]    r_bar, r_bar1, r_bar2;
  logic          r_psel1, r_psel2;
`endif

  assign w_h_last    = (r_h == H_LAST);
  assign w_v_last    = (r_v == V_LAST);
  assign w_frame_end = w_h_last && w_v_last;
  assign w_wait_done = (r_wait_h == H_LAST) && (r_wait_cnt == W_LAST);
  assign w_edge      = r_sync_s && !r_sync_d;
  // An edge arriving in the same cycle as the decision counts as already pending.
  assign w_pend_any  = r_pending || w_edge;

  assign w_vis = (r_state == S_RUN) && (32'(r_h) < H_VISIBLE) && (32'(r_v) < V_VISIBLE);
  assign w_hs  = (r_state == S_RUN) && (32'(r_h) >= H_VISIBLE + H_FP)
                 && (32'(r_h) < H_VISIBLE + H_FP + H_SYNC);
  assign w_vs  = (r_state == S_RUN) && (32'(r_v) >= V_VISIBLE + V_FP)
                 && (32'(r_v) < V_VISIBLE + V_FP + V_SYNC);

  always_comb begin
    w_state_nxt  = r_state;
    w_locked_nxt = r_locked;
    w_pend_clr   = !i_sync_en;
    if (i_enable) begin
      case (r_state)
        S_RUN: begin
          if (w_frame_end) begin
            if (!i_sync_en) begin
              w_locked_nxt = 1'b0;
            end else if (w_pend_any) begin
              w_locked_nxt = 1'b1;
              w_pend_clr   = 1'b1;
            end else begin
              w_state_nxt = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!i_sync_en) begin
            w_state_nxt  = S_RUN;
            w_locked_nxt = 1'b0;
          end else if (w_pend_any) begin
            w_state_nxt  = S_RUN;
            w_locked_nxt = 1'b1;
            w_pend_clr   = 1'b1;
          end else if (w_wait_done) begin
            w_state_nxt  = S_RUN;
            w_locked_nxt = 1'b0;
          end
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  // Synchroniser and pending flag keep running while i_enable is low.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync_m  <= 1'b0;
      r_sync_s  <= 1'b0;
      r_sync_d  <= 1'b0;
      r_pending <= 1'b0;
      r_state   <= S_RUN;
      r_locked  <= 1'b0;
    end else begin
      r_sync_m  <= i_sync;
      r_sync_s  <= r_sync_m;
      r_sync_d  <= r_sync_s;
      r_state   <= w_state_nxt;
      r_locked  <= w_locked_nxt;
      if (w_pend_clr)  r_pending <= 1'b0;
      else if (w_edge) r_pending <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h <= '0; r_hsub <= '0; r_srcx <= '0;
      r_v <= '0; r_vsub <= '0; r_srcy <= '0;
      r_wait_h <= '0; r_wait_cnt <= '0;
`ifdef TEST_PATTERN_EN
      r_bar_px <= '0; r_bar <= '0;
`endif
    end else if (i_enable) begin
      if (r_state == S_WAIT) begin
        // h and v already sit at 0; only the wait counter moves.
        if (w_state_nxt == S_RUN) begin
          r_wait_h <= '0; r_wait_cnt <= '0;
        end else if (r_wait_h == H_LAST) begin
          r_wait_h <= '0; r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
          r_wait_h <= r_wait_h + 1'b1;
        end
      end else if (w_h_last) begin
        r_h <= '0; r_hsub <= '0; r_srcx <= '0;
        if (w_v_last) begin
          r_v <= '0; r_vsub <= '0; r_srcy <= '0;
        end else begin
          r_v <= r_v + 1'b1;
          if (32'(r_vsub) == V_SCALE - 1) begin
            r_vsub <= '0; r_srcy <= r_srcy + 1'b1;
          end else begin
            r_vsub <= r_vsub + 1'b1;
          end
        end
      end else begin
        r_h <= r_h + 1'b1;
        if (32'(r_hsub) == H_SCALE - 1) begin
          r_hsub <= '0; r_srcx <= r_srcx + 1'b1;
        end else begin
          r_hsub <= r_hsub + 1'b1;
        end
      end
`ifdef TEST_PATTERN_EN
      // The last bar stops advancing so it absorbs any remainder pixels.
      if (r_state == S_WAIT || w_h_last) begin
        r_bar_px <= '0; r_bar <= '0;
      end else if (32'(r_h) < H_VISIBLE) begin
        if (32'(r_bar_px) == BAR_W - 1 && r_bar != 3'd7) begin
          r_bar_px <= '0; r_bar <= r_bar + 1'b1;
        end else begin
          r_bar_px <= r_bar_px + 1'b1;
        end
      end
`endif
    end
  end

  // The line buffer has no enable. On the first frozen cycle its data is
  // captured, so the word read before the freeze is still used on resume.
  assign w_pix = r_en_d ? i_bram_dout : r_dout_hold;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_en_d      <= 1'b0;
      r_dout_hold <= '0;
    end else begin
      r_en_d      <= i_enable;
      r_dout_hold <= w_pix;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0; r_p1 <= '0; r_p2 <= '0; r_p3 <= '0;
      r_r <= '0; r_g <= '0; r_b <= '0;
`ifdef TEST_PATTERN_EN
      r_bar1 <= '0; r_bar2 <= '0; r_psel1 <= 1'b0; r_psel2 <= 1'b0;
`endif
    end else if (i_enable) begin
      r_addr <= w_vis ? {r_srcy[0], (ADDR_W-1)'(r_srcx)} : '0;
      r_p1   <= {w_vis, w_hs, w_vs};
      r_p2   <= r_p1;
      r_p3   <= r_p2;
`ifdef TEST_PATTERN_EN
      r_bar1 <= r_bar; r_bar2 <= r_bar1;
      r_psel1 <= i_pattern_sel; r_psel2 <= r_psel1;
      if (r_p2[2] && r_psel2) begin
        // Bar order white, yellow, cyan, green, magenta, red, blue, black.
        r_r <= {8{~r_bar2[1]}};
        r_g <= {8{~r_bar2[2]}};
        r_b <= {8{~r_bar2[0]}};
      end else begin
        r_r <= r_p2[2] ? w_pix : 8'd0;
        r_g <= r_p2[2] ? w_pix : 8'd0;
        r_b <= r_p2[2] ? w_pix : 8'd0;
      end
`else
      r_r <= r_p2[2] ? w_pix : 8'd0;
      r_g <= r_p2[2] ? w_pix : 8'd0;
      r_b <= r_p2[2] ? w_pix : 8'd0;
`endif
    end
  end

  assign o_bram_addr   = r_addr;
  assign o_vga_r       = r_r;
  assign o_vga_g       = r_g;
  assign o_vga_b       = r_b;
  assign o_vga_visible = r_p3[2];
  assign o_vga_hs      = r_p3[1] ? HS_POL : !HS_POL;
  assign o_vga_vs      = r_p3[0] ? VS_POL : !VS_POL;
  assign o_locked      = r_locked;

endmodule
